pkt_gen_sf: RTL and testbench
=============================

# pkt_gen_sf

Store-and-forward header packet generator; parametrised successor of the single-channel header generator. It buffers multi-word header packets from the parser side in an internal FIFO and admits or drops each packet as a whole. It replays only complete packets to the downstream extractor, prefixing each word with a wrapping packet sequence tag. Unlike the earlier block, it adds output back-pressure, a whole-packet admission check, truncation of oversize packets, and drop/truncation statistics.

## Interface
- DATA_W, 128, header payload bits per word (flags add 2 more)
- DEPTH, 256, FIFO words; power of 2, ≥ 2*MAX_PKT
- MAX_PKT, 16, maximum words per packet; must be ≥ 2
- TAG_W, 8, sequence tag width
- CNT_W, 16, statistics counter width
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- headerData_valid  in  1  input word valid (no back-pressure)
- headerData  in  DATA_W+2  [DATA_W+1:DATA_W] flag: 10 first, 00 middle, 01 last, 11 single-word; [DATA_W-1:0] payload
- headerIn_enable  in  1  admission enable, sampled on a packet's first word only
- headerData_out_valid  out  1  output word valid
- headerData_out  out  TAG_W+DATA_W+2  {tag, flag, payload}
- headerData_out_ready  in  1  downstream accepts the word on a rising edge when valid & ready
- pkt_pending  out  log2(DEPTH)+1  complete packets held in the FIFO
- drop_count  out  CNT_W  packets dropped; saturating
- trunc_count  out  CNT_W  packets truncated; saturating

## Operation
- Input FSM states: IDLE, PASS, DISCARD. In IDLE, any valid word is treated as a packet start, whatever its flag.
- Admission at start word: admit iff headerIn_enable=1 and free words ≥ MAX_PKT. Free words = DEPTH − used − in-flight write.
- Admitted word with a last flag (01 or 11): written, stay IDLE. Otherwise go to PASS.
- Rejected start word: drop_count+1. If it is last, stay IDLE; otherwise go to DISCARD.
- PASS: every valid word is written. A last flag returns the FSM to IDLE.
- PASS, word number MAX_PKT without a last flag: its flag is rewritten to 01 and written, trunc_count+1, go to DISCARD.
- DISCARD: valid words are not written. A last flag returns the FSM to IDLE.
- Writing a last-flagged word increments pkt_pending.
- Output FSM states: IDLE, READ, HOLD.
  - IDLE: if pkt_pending>0, issue a FIFO read and go to READ.
  - READ: FIFO data is registered into headerData_out with the current tag, valid=1, go to HOLD.
  - HOLD: on handshake, if the word was last, tag+1 (wraps mod 2^TAG_W), pkt_pending−1, go to IDLE. Otherwise issue the next read and go to READ.
- Packet words are emitted contiguously with no interleaving. A packet is never split by the tag changing.
- pkt_pending increment and decrement in the same cycle: net unchanged.
- Statistics counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- Reset values: headerData_out_valid=0, headerData_out=0, pkt_pending=0, drop_count=0, trunc_count=0, tag=0. Both FSMs go to IDLE and the FIFO is cleared.
- Input word sampled at edge T is written to the FIFO at edge T+1 (one register stage).
- Last word sampled at T: pkt_pending increments at T+1. The read is issued at T+2. The first output word is valid after T+3.
- Output is registered. Data and valid stay stable while valid=1 and ready=0.
- Throughput: one output word per 2 cycles (READ/HOLD alternation). The input side accepts a word every cycle.
- Reset asserted mid-packet: the partial packet is lost, nothing is emitted after release, and the counters are cleared.

## Structure
- Package pkt_gen_pkg: flag constants FLAG_FIRST=2'b10, FLAG_MID=2'b00, FLAG_LAST=2'b01, FLAG_SINGLE=2'b11, plus an is_last(flag) function.
- Sub-module sc_fifo (WIDTH, DEPTH):
  - synchronous, non-show-ahead, read latency 1;
  - ports clk, aclr, data, wrreq, rdreq, q, empty, full, usedw.
- Instantiate sc_fifo with aclr driven from !reset.

## Test plan
- Single 3-word packet (10,00,01), enable=1, ready=1 → 3 output words with tag 0 and unchanged flags; first output valid 3 cycles after the last input edge; pkt_pending returns to 0.
- Two packets back-to-back, ready held 0 for 10 cycles → pkt_pending=2, first word held stable; after release, tags 0 then 1.
- Start word with enable=0 → whole packet absent from output, drop_count=1, the next packet passes with tag 0.
- MAX_PKT=4, 6-word packet → 4 words out, 4th flag 01, trunc_count=1; a following packet is unaffected.
- Fill until free words < MAX_PKT with ready=0 → the next packet is dropped (drop_count+1), no FIFO overflow; after draining, a new packet is admitted.
- 2^TAG_W+1 single-word packets → tag wraps to 0 on packet 2^TAG_W; reset mid-packet → all outputs 0 and no partial packet emitted.

Source files
------------

// File: rtl/pkt_gen_pkg.sv
// Shared definitions for the store-and-forward header packet generator.
//   - two-bit word flags carried with every header word
//   - state encodings for the input (admission) and output (replay) FSMs
//   - is_last(): true for flags that close a packet (last or single-word)
package pkt_gen_pkg;

    localparam logic [1:0] FLAG_FIRST  = 2'b10;
    localparam logic [1:0] FLAG_MID    = 2'b00;
    localparam logic [1:0] FLAG_LAST   = 2'b01;
    localparam logic [1:0] FLAG_SINGLE = 2'b11;

    typedef enum logic [1:0] {
        IN_IDLE,
        IN_PASS,
        IN_DISCARD
    } in_state_e;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_READ,
        OUT_HOLD
    } out_state_e;

    function automatic logic is_last(input logic [1:0] flag);
        return (flag == FLAG_LAST) || (flag == FLAG_SINGLE);
    endfunction

endpackage

// File: rtl/sc_fifo.sv
// Single-clock FIFO, non-show-ahead: q updates one edge after rdreq.
// Ports:
//   clk    - clock
//   aclr   - asynchronous clear, active-high (empties the FIFO, clears q)
//   data   - write data, written when wrreq and not full
//   wrreq  - write request
//   rdreq  - read request, honoured when not empty
//   q      - read data (registered)
//   empty  - no words stored
//   full   - DEPTH words stored
//   usedw  - words stored, 0..DEPTH
module sc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     aclr,
    input  logic [WIDTH-1:0]         data,
    input  logic                     wrreq,
    input  logic                     rdreq,
    output logic [WIDTH-1:0]         q,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   usedw
);

    localparam int AW = $clog2(DEPTH);
    localparam int UW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (usedw == '0);
    assign full  = (usedw == UW'(DEPTH));
    assign do_wr = wrreq && !full;
    assign do_rd = rdreq && !empty;

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= data;
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            wptr  <= '0;
            rptr  <= '0;
            usedw <= '0;
            q     <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + AW'(1);
            end
            if (do_rd) begin
                q    <= mem[rptr];
                rptr <= rptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   usedw <= usedw + UW'(1);
                2'b01:   usedw <= usedw - UW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pkt_gen_sf.sv
// Store-and-forward header packet generator.
// Buffers header packets in a FIFO, admits or drops each packet as a whole
// on its first word, truncates packets longer than MAX_PKT words, and replays
// only complete packets downstream with a wrapping per-packet sequence tag.
// Ports:
//   clk                   - clock
//   reset                 - asynchronous reset, active-low
//   headerData_valid      - input word valid (no back-pressure)
//   headerData            - {flag[1:0], payload}
//   headerIn_enable       - admission enable, looked at on a start word only
//   headerData_out_valid  - output word valid
//   headerData_out        - {tag, flag, payload}
//   headerData_out_ready  - downstream accepts when valid & ready
//   pkt_pending           - complete packets held in the FIFO
//   drop_count            - dropped packets, saturating
//   trunc_count           - truncated packets, saturating
//
// Input FSM
//   state      | meaning
//   IN_IDLE    | waiting for a start word; any valid word starts a packet
//   IN_PASS    | admitted packet in progress, words are written
//   IN_DISCARD | rejected or truncated packet, words skipped until last flag
// Output FSM
//   state      | meaning
//   OUT_IDLE   | waiting for a complete packet; read issued on leaving
//   OUT_READ   | FIFO read data arrives, registered onto the output
//   OUT_HOLD   | word presented, waiting for ready
module pkt_gen_sf
    import pkt_gen_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int DEPTH   = 256,
    parameter int MAX_PKT = 16,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          headerData_valid,
    input  logic [DATA_W+1:0]             headerData,
    input  logic                          headerIn_enable,
    output logic                          headerData_out_valid,
    output logic [TAG_W+DATA_W+1:0]       headerData_out,
    input  logic                          headerData_out_ready,
    output logic [$clog2(DEPTH):0]        pkt_pending,
    output logic [CNT_W-1:0]              drop_count,
    output logic [CNT_W-1:0]              trunc_count
);

    localparam int UW   = $clog2(DEPTH) + 1;
    localparam int WC_W = $clog2(MAX_PKT + 1);

    in_state_e          in_state;
    out_state_e         out_state;

    logic               wr_req_q;
    logic [DATA_W+1:0]  wr_data_q;
    logic [WC_W-1:0]    word_cnt;
    logic [TAG_W-1:0]   tag;

    logic               fifo_aclr;
    logic               fifo_wrreq;
    logic               fifo_rdreq;
    logic [DATA_W+1:0]  fifo_q;
    logic               fifo_empty;
    logic               fifo_full;
    logic [UW-1:0]      fifo_usedw;

    logic [1:0]         in_flag;
    logic               room_ok;
    logic               out_fire;
    logic               out_last;
    logic               pend_inc;
    logic               pend_dec;

    assign in_flag = headerData[DATA_W+1:DATA_W];

    // Room for a worst-case packet, counting the word still in the write stage.
    assign room_ok = (int'(fifo_usedw) + int'(wr_req_q) + MAX_PKT) <= DEPTH;

    assign fifo_aclr  = ~reset;
    assign fifo_wrreq = wr_req_q && !fifo_full;

    sc_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .aclr  (fifo_aclr),
        .data  (wr_data_q),
        .wrreq (fifo_wrreq),
        .rdreq (fifo_rdreq),
        .q     (fifo_q),
        .empty (fifo_empty),
        .full  (fifo_full),
        .usedw (fifo_usedw)
    );

    // Input side: admission, truncation, one-stage write register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_state    <= IN_IDLE;
            wr_req_q    <= 1'b0;
            wr_data_q   <= '0;
            word_cnt    <= '0;
            drop_count  <= '0;
            trunc_count <= '0;
        end else begin
            wr_req_q <= 1'b0;
            if (headerData_valid) begin
                case (in_state)
                    IN_IDLE: begin
                        if (headerIn_enable && room_ok) begin
                            wr_req_q  <= 1'b1;
                            wr_data_q <= headerData;
                            word_cnt  <= WC_W'(1);
                            if (!is_last(in_flag)) begin
                                in_state <= IN_PASS;
                            end
                        end else begin
                            if (drop_count != '1) begin
                                drop_count <= drop_count + CNT_W'(1);
                            end
                            if (!is_last(in_flag)) begin
                                in_state <= IN_DISCARD;
                            end
                        end
                    end
                    IN_PASS: begin
                        wr_req_q <= 1'b1;
                        word_cnt <= word_cnt + WC_W'(1);
                        if (is_last(in_flag)) begin
                            wr_data_q <= headerData;
                            in_state  <= IN_IDLE;
                        end else if (word_cnt == WC_W'(MAX_PKT - 1)) begin
                            // Oversize: close the stored packet here, skip the rest.
                            wr_data_q <= {FLAG_LAST, headerData[DATA_W-1:0]};
                            in_state  <= IN_DISCARD;
                            if (trunc_count != '1) begin
                                trunc_count <= trunc_count + CNT_W'(1);
                            end
                        end else begin
                            wr_data_q <= headerData;
                        end
                    end
                    IN_DISCARD: begin
                        if (is_last(in_flag)) begin
                            in_state <= IN_IDLE;
                        end
                    end
                    default: in_state <= IN_IDLE;
                endcase
            end
        end
    end

    assign out_fire = headerData_out_valid && headerData_out_ready;
    assign out_last = is_last(headerData_out[DATA_W+1:DATA_W]);
    assign pend_inc = fifo_wrreq && is_last(wr_data_q[DATA_W+1:DATA_W]);
    assign pend_dec = (out_state == OUT_HOLD) && out_fire && out_last;

    always_comb begin
        fifo_rdreq = 1'b0;
        case (out_state)
            OUT_IDLE: fifo_rdreq = (pkt_pending != '0) && !fifo_empty;
            OUT_HOLD: fifo_rdreq = out_fire && !out_last;
            default:  fifo_rdreq = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_pending <= '0;
        end else if (pend_inc && !pend_dec) begin
            pkt_pending <= pkt_pending + UW'(1);
        end else if (pend_dec && !pend_inc) begin
            pkt_pending <= pkt_pending - UW'(1);
        end
    end

    // Output side: a packet is replayed word by word under one tag value;
    // the tag only advances after the last word is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_state            <= OUT_IDLE;
            headerData_out_valid <= 1'b0;
            headerData_out       <= '0;
            tag                  <= '0;
        end else begin
            case (out_state)
                OUT_IDLE: begin
                    if (fifo_rdreq) begin
                        out_state <= OUT_READ;
                    end
                end
                OUT_READ: begin
                    headerData_out       <= {tag, fifo_q};
                    headerData_out_valid <= 1'b1;
                    out_state            <= OUT_HOLD;
                end
                OUT_HOLD: begin
                    if (out_fire) begin
                        headerData_out_valid <= 1'b0;
                        if (out_last) begin
                            tag       <= tag + TAG_W'(1);
                            out_state <= OUT_IDLE;
                        end else begin
                            out_state <= OUT_READ;
                        end
                    end
                end
                default: out_state <= OUT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_gen_sf.sv
module tb_pkt_gen_sf;
    import pkt_gen_pkg::*;

    localparam int DW    = 16;
    localparam int DEP   = 16;
    localparam int MP    = 4;
    localparam int TW    = 4;
    localparam int CW    = 4;
    localparam int OUT_W = TW + DW + 2;
    localparam int PW    = $clog2(DEP) + 1;
    localparam int CMAX  = (1 << CW) - 1;

    logic              clk;
    logic              reset;
    logic              headerData_valid;
    logic [DW+1:0]     headerData;
    logic              headerIn_enable;
    logic              headerData_out_valid;
    logic [OUT_W-1:0]  headerData_out;
    logic              headerData_out_ready;
    logic [PW-1:0]     pkt_pending;
    logic [CW-1:0]     drop_count;
    logic [CW-1:0]     trunc_count;

    pkt_gen_sf #(
        .DATA_W (DW),
        .DEPTH  (DEP),
        .MAX_PKT(MP),
        .TAG_W  (TW),
        .CNT_W  (CW)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .headerData_valid     (headerData_valid),
        .headerData           (headerData),
        .headerIn_enable      (headerIn_enable),
        .headerData_out_valid (headerData_out_valid),
        .headerData_out       (headerData_out),
        .headerData_out_ready (headerData_out_ready),
        .pkt_pending          (pkt_pending),
        .drop_count           (drop_count),
        .trunc_count          (trunc_count)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] exp_w;
    logic [TW-1:0]    exp_tag;
    int               exp_drop;
    int               exp_trunc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every accepted output word must match the queue head.
    always @(negedge clk) begin
        if (reset && headerData_out_valid && headerData_out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_word got=%h required=none", headerData_out);
            end else begin
                exp_w = exp_q.pop_front();
                if (headerData_out !== exp_w) begin
                    n_err++;
                    $display("FAIL out_word got=%h required=%h", headerData_out, exp_w);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        headerData_valid = 1'b0;
        headerData       = '0;
        headerIn_enable  = 1'b0;
        reset            = 1'b0;
        exp_q.delete();
        exp_tag   = '0;
        exp_drop  = 0;
        exp_trunc = 0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    // Drives one packet of n words; the model decides what should come out.
    task automatic send_pkt(input int n, input logic en, input logic admit);
        logic [1:0]    f;
        logic [1:0]    ef;
        logic [DW-1:0] p;
        for (int i = 0; i < n; i++) begin
            if (n == 1)          f = FLAG_SINGLE;
            else if (i == 0)     f = FLAG_FIRST;
            else if (i == n - 1) f = FLAG_LAST;
            else                 f = FLAG_MID;
            p  = DW'($urandom);
            ef = (n > MP && i == MP - 1) ? FLAG_LAST : f;
            if (admit && i < MP) exp_q.push_back({exp_tag, ef, p});
            headerData_valid = 1'b1;
            headerData       = {f, p};
            headerIn_enable  = (i == 0) ? en : 1'b0;
            tick();
        end
        headerData_valid = 1'b0;
        headerIn_enable  = 1'b0;
        if (admit) begin
            exp_tag = exp_tag + 1'b1;
            if (n > MP && exp_trunc < CMAX) exp_trunc++;
        end else if (exp_drop < CMAX) begin
            exp_drop++;
        end
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        headerData_out_ready = 1'b1;
        do_reset();
        n_vec++; if (headerData_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b required=0", headerData_out_valid); end
        n_vec++; if (headerData_out !== '0) begin n_err++; $display("FAIL rst_data got=%h required=0", headerData_out); end
        n_vec++; if (pkt_pending !== '0) begin n_err++; $display("FAIL rst_pending got=%0d required=0", pkt_pending); end
        n_vec++; if (drop_count !== '0) begin n_err++; $display("FAIL rst_drop got=%0d required=0", drop_count); end
        n_vec++; if (trunc_count !== '0) begin n_err++; $display("FAIL rst_trunc got=%0d required=0", trunc_count); end
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        headerData_out_ready = 1'b1;
        send_pkt(3, 1'b1, 1'b1);
        tick();   // T+1
        n_vec++; if (pkt_pending !== PW'(1)) begin n_err++; $display("FAIL single_pending_inc got=%0d required=1", pkt_pending); end
        n_vec++; if (headerData_out_valid !== 1'b0) begin n_err++; $display("FAIL single_early_t1 got=%b required=0", headerData_out_valid); end
        tick();   // T+2
        n_vec++; if (headerData_out_valid !== 1'b0) begin n_err++; $display("FAIL single_early_t2 got=%b required=0", headerData_out_valid); end
        tick();   // T+3
        n_vec++; if (headerData_out_valid !== 1'b1) begin n_err++; $display("FAIL single_latency got=%b required=1", headerData_out_valid); end
        wait_drain(50, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL single_drain got=%0d_left required=0", exp_q.size()); end
        n_vec++; if (pkt_pending !== '0) begin n_err++; $display("FAIL single_pending_end got=%0d required=0", pkt_pending); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        headerData_out_ready = 1'b0;
        send_pkt(3, 1'b1, 1'b1);
        send_pkt(2, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++; if (headerData_out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_hold_valid cyc=%0d got=%b required=1", i, headerData_out_valid); end
            n_vec++; if (headerData_out !== exp_q[0]) begin n_err++; $display("FAIL b2b_hold_data cyc=%0d got=%h required=%h", i, headerData_out, exp_q[0]); end
        end
        n_vec++; if (pkt_pending !== PW'(2)) begin n_err++; $display("FAIL b2b_pending got=%0d required=2", pkt_pending); end
        headerData_out_ready = 1'b1;
        wait_drain(100, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_drain got=%0d_left required=0", exp_q.size()); end
        n_vec++; if (pkt_pending !== '0) begin n_err++; $display("FAIL b2b_pending_end got=%0d required=0", pkt_pending); end
    endtask

    task automatic test_drop();
        bit ok;
        do_reset();
        headerData_out_ready = 1'b1;
        send_pkt(3, 1'b0, 1'b0);
        send_pkt(2, 1'b1, 1'b1);
        wait_drain(50, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL drop_drain got=%0d_left required=0", exp_q.size()); end
        n_vec++; if (drop_count !== CW'(exp_drop)) begin n_err++; $display("FAIL drop_count got=%0d required=%0d", drop_count, exp_drop); end
    endtask

    task automatic test_trunc();
        bit ok;
        do_reset();
        headerData_out_ready = 1'b1;
        send_pkt(6, 1'b1, 1'b1);
        send_pkt(2, 1'b1, 1'b1);
        send_pkt(MP, 1'b1, 1'b1);
        wait_drain(100, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL trunc_drain got=%0d_left required=0", exp_q.size()); end
        n_vec++; if (trunc_count !== CW'(exp_trunc)) begin n_err++; $display("FAIL trunc_count got=%0d required=%0d", trunc_count, exp_trunc); end
        n_vec++; if (drop_count !== '0) begin n_err++; $display("FAIL trunc_drop got=%0d required=0", drop_count); end
    endtask

    task automatic test_fill();
        bit ok;
        do_reset();
        headerData_out_ready = 1'b0;
        // One word sits in the output register, so four packets leave 15 words
        // stored: the fifth start word sees only one free word.
        for (int k = 0; k < 4; k++) send_pkt(MP, 1'b1, 1'b1);
        send_pkt(MP, 1'b1, 1'b0);
        repeat (3) tick();
        n_vec++; if (drop_count !== CW'(exp_drop)) begin n_err++; $display("FAIL fill_drop got=%0d required=%0d", drop_count, exp_drop); end
        n_vec++; if (pkt_pending !== PW'(4)) begin n_err++; $display("FAIL fill_pending got=%0d required=4", pkt_pending); end
        headerData_out_ready = 1'b1;
        wait_drain(200, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL fill_drain got=%0d_left required=0", exp_q.size()); end
        send_pkt(MP, 1'b1, 1'b1);
        wait_drain(50, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL fill_readmit got=%0d_left required=0", exp_q.size()); end
        n_vec++; if (drop_count !== CW'(exp_drop)) begin n_err++; $display("FAIL fill_drop_end got=%0d required=%0d", drop_count, exp_drop); end
    endtask

    task automatic test_tag_wrap();
        bit ok;
        do_reset();
        headerData_out_ready = 1'b1;
        for (int k = 0; k < (1 << TW) + 1; k++) begin
            send_pkt(1, 1'b1, 1'b1);
            repeat (3) tick();
        end
        wait_drain(100, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL wrap_drain got=%0d_left required=0", exp_q.size()); end
        n_vec++; if (drop_count !== '0) begin n_err++; $display("FAIL wrap_drop got=%0d required=0", drop_count); end
    endtask

    task automatic test_saturate();
        do_reset();
        headerData_out_ready = 1'b1;
        for (int k = 0; k < CMAX; k++) send_pkt(1, 1'b0, 1'b0);
        n_vec++; if (drop_count !== CW'(CMAX)) begin n_err++; $display("FAIL sat_drop_max got=%0d required=%0d", drop_count, CMAX); end
        send_pkt(1, 1'b0, 1'b0);
        send_pkt(1, 1'b0, 1'b0);
        tick();
        n_vec++; if (drop_count !== CW'(CMAX)) begin n_err++; $display("FAIL sat_drop_hold got=%0d required=%0d", drop_count, CMAX); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        headerData_out_ready = 1'b1;
        send_pkt(2, 1'b0, 1'b0);
        send_pkt(6, 1'b1, 1'b1);
        wait_drain(100, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL rmid_drain got=%0d_left required=0", exp_q.size()); end
        n_vec++; if (trunc_count !== CW'(1)) begin n_err++; $display("FAIL rmid_trunc_pre got=%0d required=1", trunc_count); end
        headerData_valid = 1'b1;
        headerIn_enable  = 1'b1;
        headerData       = {FLAG_FIRST, DW'($urandom)};
        tick();
        headerIn_enable  = 1'b0;
        headerData       = {FLAG_MID, DW'($urandom)};
        tick();
        headerData_valid = 1'b0;
        reset = 1'b0;
        #2;
        n_vec++; if (headerData_out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got=%b required=0", headerData_out_valid); end
        n_vec++; if (headerData_out !== '0) begin n_err++; $display("FAIL rmid_data got=%h required=0", headerData_out); end
        n_vec++; if (drop_count !== '0) begin n_err++; $display("FAIL rmid_drop got=%0d required=0", drop_count); end
        n_vec++; if (trunc_count !== '0) begin n_err++; $display("FAIL rmid_trunc got=%0d required=0", trunc_count); end
        repeat (2) tick();
        reset = 1'b1;
        repeat (12) tick();
        n_vec++; if (pkt_pending !== '0) begin n_err++; $display("FAIL rmid_pending got=%0d required=0", pkt_pending); end
        n_vec++; if (headerData_out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_no_emit got=%b required=0", headerData_out_valid); end
    endtask

    initial begin
        reset                = 1'b0;
        headerData_valid     = 1'b0;
        headerData           = '0;
        headerIn_enable      = 1'b0;
        headerData_out_ready = 1'b0;
        exp_tag              = '0;
        exp_drop             = 0;
        exp_trunc            = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_drop();
        test_trunc();
        test_fill();
        test_tag_wrap();
        test_saturate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
